demux_deserializer_8: RTL and testbench

- Receive-side counterpart of the 8-to-1 select mux path. The mux end drives one N-bit symbol per step as S walks 0..7. This block takes that symbol stream and distributes symbol k into lane k of an 8-lane parallel word.
- Uses a 3-bit lane counter driving a 1-to-8 write-enable demux, frame-start alignment, and a valid/ready output register with overrun detection.
- Sits between the serial symbol source and any parallel consumer in the HW1 datapath.

---
 rtl/deser_pkg.sv | 17 +
 rtl/demux_lane_decode.sv | 15 +
 rtl/demux_deserializer_8.sv | 107 ++++++++++
 tb/tb_demux_deserializer_8.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared constants, state encoding and lane addressing for the 8-lane symbol deserializer.
package deser_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit offset of lane k inside a word built from n-bit lanes.
  function automatic int lane_slice(input int k, input int n);
    return k * n;
  endfunction

endpackage

// File: rtl/demux_lane_decode.sv
// 1-to-8 lane write-enable decoder: the inverse of the 8-to-1 symbol select.
module demux_lane_decode
  import deser_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [LANES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_deserializer_8.sv
// Collects a stream of N-bit symbols into an 8-lane parallel word with frame-start
// alignment, a valid/ready output register and overrun detection.
module demux_deserializer_8
  import deser_pkg::*;
#(
  parameter int N = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       serial_in,
  input  logic               in_valid,
  input  logic               start,
  output logic [LANES*N-1:0] data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               frame_err,
  output logic               overrun
);

  state_t             state_p0, state_nxt;
  logic [SEL_W-1:0]   sel_p0, sel_nxt, wr_sel;
  logic               wr_en, complete, ferr_nxt;
  logic [LANES-1:0]   lane_we;
  logic [LANES*N-1:0] shadow_p0, word_asm;

  always_comb begin
    state_nxt = state_p0;
    sel_nxt   = sel_p0;
    wr_sel    = sel_p0;
    wr_en     = 1'b0;
    complete  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state_p0)
      IDLE: begin
        if (in_valid && start) begin
          wr_en     = 1'b1;
          wr_sel    = '0;
          sel_nxt   = SEL_W'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (start) begin
            // Realign: the partial frame is abandoned and this symbol becomes lane 0.
            ferr_nxt = 1'b1;
            wr_sel   = '0;
            sel_nxt  = SEL_W'(1);
          end else begin
            sel_nxt = sel_p0 + SEL_W'(1);
            if (sel_p0 == SEL_W'(LANES - 1)) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  demux_lane_decode u_decode (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (lane_we)
  );

  // Merge the incoming symbol into its lane so the completing word includes lane 7.
  always_comb begin
    word_asm = shadow_p0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_we[k]) word_asm[lane_slice(k, N) +: N] = serial_in;
    end
  end

  // ---- stage p0: shadow assembly, lane counter and output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0  <= IDLE;
      sel_p0    <= '0;
      shadow_p0 <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_p0  <= state_nxt;
      sel_p0    <= sel_nxt;
      shadow_p0 <= word_asm;
      frame_err <= ferr_nxt;
      overrun   <= complete && out_valid && !out_ready;
      if (complete && (!out_valid || out_ready)) begin
        data_out  <= word_asm;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign sel  = sel_p0;
  assign busy = (state_p0 == SHIFT);

endmodule

// File: tb/tb_demux_deserializer_8.sv
// Scoreboard bench: an N=4 and an N=1 deserializer share one stimulus stream and are
// checked against a frame-level queue model of symbol collection and word handoff.
module tb_demux_deserializer_8;

  logic        clk = 1'b0;
  logic        reset, in_valid, start, out_ready;
  logic [3:0]  serial_in;
  logic [0:0]  serial_in1;
  logic [31:0] data_out4;
  logic [7:0]  data_out1;
  logic        ov4, ov1, busy4, busy1, ferr4, ferr1, ovr4, ovr1;
  logic [2:0]  sel4, sel1;

  always #5 clk = ~clk;
  assign serial_in1 = serial_in[0];

  demux_deserializer_8 #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .serial_in(serial_in), .in_valid(in_valid), .start(start),
    .data_out(data_out4), .out_valid(ov4), .out_ready(out_ready), .sel(sel4),
    .busy(busy4), .frame_err(ferr4), .overrun(ovr4)
  );

  demux_deserializer_8 #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .serial_in(serial_in1), .in_valid(in_valid), .start(start),
    .data_out(data_out1), .out_valid(ov1), .out_ready(out_ready), .sel(sel1),
    .busy(busy1), .frame_err(ferr1), .overrun(ovr1)
  );

  typedef struct {
    logic        ov;
    logic [2:0]  sel;
    logic        busy;
    logic        ferr;
    logic        ovr;
    logic [31:0] d4;
    logic [7:0]  d1;
  } exp_t;

  exp_t        ctl_q[$];
  logic [39:0] data_q[$];
  int          checks = 0;
  int          failures = 0;

  logic [3:0]  m_frame[$];
  logic        m_ov = 1'b0;
  logic [31:0] m_d4 = '0;
  logic [7:0]  m_d1 = '0;
  logic        prev_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances a frame-level view of the same cycle.
  task automatic step(input logic iv, input logic st, input logic [3:0] sym,
                      input logic rdy, input logic rs);
    exp_t        e;
    logic        ferr, ovr, done;
    logic [31:0] w4;
    logic [7:0]  w1;
    @(negedge clk);
    reset = rs; in_valid = iv; start = st; serial_in = sym; out_ready = rdy;
    ferr = 1'b0; ovr = 1'b0; done = 1'b0; w4 = '0; w1 = '0;
    if (rs) begin
      m_frame.delete();
      m_ov = 1'b0; m_d4 = '0; m_d1 = '0;
    end else begin
      if (iv) begin
        if (st) begin
          ferr = (m_frame.size() > 0);
          m_frame.delete();
          m_frame.push_back(sym);
        end else if (m_frame.size() > 0) begin
          m_frame.push_back(sym);
        end
      end
      if (m_frame.size() == 8) begin
        for (int k = 0; k < 8; k++) begin
          w4[k*4 +: 4] = m_frame[k];
          w1[k]        = m_frame[k][0];
        end
        m_frame.delete();
        done = 1'b1;
      end
      if (done) begin
        if (!m_ov || rdy) begin
          m_ov = 1'b1; m_d4 = w4; m_d1 = w1;
          data_q.push_back({w1, w4});
        end else begin
          ovr = 1'b1;
        end
      end else if (m_ov && rdy) begin
        m_ov = 1'b0;
      end
    end
    e.ov = m_ov; e.sel = 3'(m_frame.size()); e.busy = (m_frame.size() > 0);
    e.ferr = ferr; e.ovr = ovr; e.d4 = m_d4; e.d1 = m_d1;
    ctl_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, rdy, 1'b0);
  endtask

  // Send an 8-symbol N=1-style frame (lane k = bit k), optional stall after lane gap_at.
  task automatic send_bits(input logic [7:0] b, input logic rdy_body, input logic rdy_last,
                           input int gap_at, input int gap_len);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k == 0, {3'b000, b[k]}, (k == 7) ? rdy_last : rdy_body, 1'b0);
      if (k == gap_at) idle(gap_len, rdy_body);
    end
  endtask

  // Monitor: per-cycle control/data check, plus word pop whenever a new word is presented.
  initial begin
    exp_t        e;
    logic [39:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (ctl_q.size() > 0) begin
        e = ctl_q.pop_front();
        chk("out_valid_n4", {31'b0, ov4}, {31'b0, e.ov});
        chk("out_valid_n1", {31'b0, ov1}, {31'b0, e.ov});
        chk("sel_n4", {29'b0, sel4}, {29'b0, e.sel});
        chk("sel_n1", {29'b0, sel1}, {29'b0, e.sel});
        chk("busy_n4", {31'b0, busy4}, {31'b0, e.busy});
        chk("busy_n1", {31'b0, busy1}, {31'b0, e.busy});
        chk("frame_err_n4", {31'b0, ferr4}, {31'b0, e.ferr});
        chk("frame_err_n1", {31'b0, ferr1}, {31'b0, e.ferr});
        chk("overrun_n4", {31'b0, ovr4}, {31'b0, e.ovr});
        chk("overrun_n1", {31'b0, ovr1}, {31'b0, e.ovr});
        chk("data_out_n4", data_out4, e.d4);
        chk("data_out_n1", {24'b0, data_out1}, {24'b0, e.d1});
        if (ov4 === 1'b1 && (!prev_ov || out_ready === 1'b1)) begin
          checks++;
          if (data_q.size() == 0) begin
            failures++;
            $display("FAIL word_event actual=unexpected_word expected=no_word at %0t", $time);
          end else begin
            w = data_q.pop_front();
            chk("word_n4", data_out4, w[31:0]);
            chk("word_n1", {24'b0, data_out1}, {24'b0, w[39:32]});
          end
        end
        prev_ov = ov4;
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; start = 1'b0; serial_in = '0; out_ready = 1'b0;
    void'($urandom(32'h00C0FFEE));
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

    // Basic frame A..H = 1,0,1,1,0,0,1,0 and the stalled variant.
    send_bits(8'h4D, 1'b1, 1'b1, -1, 0);
    idle(3, 1'b1);
    send_bits(8'h4D, 1'b1, 1'b1, 3, 3);
    idle(3, 1'b1);

    // Mid-frame restart after 5 symbols; the word must come out as 0x01.
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, 4'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Overrun with the consumer stalled, then simultaneous handoff on completion.
    send_bits(8'hA5, 1'b0, 1'b0, -1, 0);
    send_bits(8'h3C, 1'b0, 1'b0, -1, 0);
    idle(3, 1'b0);
    idle(2, 1'b1);
    send_bits(8'hA5, 1'b0, 1'b0, -1, 0);
    send_bits(8'h3C, 1'b0, 1'b1, -1, 0);
    idle(3, 1'b1);

    // Reset mid-frame while a word is pending, then idle garbage without start.
    send_bits(8'hA5, 1'b0, 1'b0, -1, 0);
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, 4'h1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Random 4-bit frames with stalls and a randomly throttled consumer.
    for (int f = 0; f < 9; f++) begin
      for (int k = 0; k < 8; k++) begin
        while ($urandom_range(0, 3) == 0)
          step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        step(1'b1, k == 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    idle(4, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    chk("ctl_q_drain", ctl_q.size(), 0);
    chk("data_q_drain", data_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
